// File: rtl/cp0_int_regs_if.sv
// CP0 interrupt register block bus: encoder request/proposal, CPU entry/return
// handshake and the mtc0/mfc0 port.
interface cp0_int_regs_if;
    logic        int_req;
    logic [31:0] int_epc;
    logic [31:0] int_cause;
    logic [31:0] int_status;
    logic        boundary;
    logic        take;
    logic [31:0] vector;
    logic        eret;
    logic [31:0] epc_out;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] status_out;
    logic [31:0] isr_out;

    modport slave (
        input  int_req, int_epc, int_cause, int_status, boundary, eret,
               cp0_we, cp0_addr, cp0_wdata,
        output take, vector, epc_out, cp0_rdata, status_out, isr_out
    );

    modport master (
        output int_req, int_epc, int_cause, int_status, boundary, eret,
               cp0_we, cp0_addr, cp0_wdata,
        input  take, vector, epc_out, cp0_rdata, status_out, isr_out
    );
endinterface

// File: rtl/cp0_int_regs.sv
// CP0 interrupt registers: commits encoder proposals at instruction boundaries,
// sequences entry/flush/eret. Define CP0_EPC_STACK_EN for a 4-deep EPC stack.
//
// state | meaning
// IDLE  | accepting take, eret and mtc0
// FLUSH | blanking after entry; take held 0, eret/mtc0 dropped
module cp0_int_regs #(
    parameter logic [31:0] VECTOR       = 32'h0000_0008,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    cp0_int_regs_if.slave bus
);
    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] isr_q, isr_d;
    logic        full, take, do_eret, do_we;
    logic [31:0] low_bit, epc_top;

`ifdef CP0_EPC_STACK_EN
    logic [31:0] stk_q [4];
    logic [31:0] stk_d [4];
    logic [2:0]  depth_q, depth_d;

    assign full    = (depth_q == 3'd4);
    assign epc_top = (depth_q == 3'd0) ? 32'd0 : stk_q[2'(depth_q - 3'd1)];
`else
    logic [31:0] epc_q, epc_d;

    assign full    = 1'b0;
    assign epc_top = epc_q;
`endif

    assign take    = (state_q == IDLE) & bus.int_req & bus.boundary & ~full;
    assign do_eret = (state_q == IDLE) & bus.eret & ~take;
    assign do_we   = (state_q == IDLE) & bus.cp0_we & ~take & ~bus.eret;
    // isolates the lowest in-service bit (zero when ISR is empty)
    assign low_bit = isr_q & (~isr_q + 32'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        cause_d  = cause_q;
        isr_d    = isr_q;
`ifdef CP0_EPC_STACK_EN
        stk_d    = stk_q;
        depth_d  = depth_q;
`else
        epc_d    = epc_q;
`endif
        case (state_q)
            IDLE: begin
                if (take) begin
                    status_d = bus.int_status;
                    cause_d  = bus.int_cause;
                    isr_d    = isr_q | (bus.int_status & ~status_q);
                    cnt_d    = 4'(FLUSH_CYCLES - 1);
                    state_d  = FLUSH;
`ifdef CP0_EPC_STACK_EN
                    stk_d[depth_q[1:0]] = bus.int_epc;
                    depth_d             = depth_q + 3'd1;
`else
                    epc_d    = bus.int_epc;
`endif
                end else if (do_eret) begin
                    isr_d    = isr_q & ~low_bit;
                    status_d = status_q & ~low_bit;
`ifdef CP0_EPC_STACK_EN
                    if (depth_q != 3'd0) depth_d = depth_q - 3'd1;
`endif
                end else if (do_we) begin
                    case (bus.cp0_addr)
                        5'd12: status_d = bus.cp0_wdata;
                        5'd13: cause_d  = bus.cp0_wdata;
`ifdef CP0_EPC_STACK_EN
                        5'd14: if (depth_q != 3'd0) stk_d[2'(depth_q - 3'd1)] = bus.cp0_wdata;
`else
                        5'd14: epc_d    = bus.cp0_wdata;
`endif
                        default: ;
                    endcase
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            status_q <= 32'hFFFF_FFFF;
            cause_q  <= 32'd0;
            isr_q    <= 32'd0;
`ifdef CP0_EPC_STACK_EN
            for (int i = 0; i < 4; i++) stk_q[i] <= 32'd0;
            depth_q  <= 3'd0;
`else
            epc_q    <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            cause_q  <= cause_d;
            isr_q    <= isr_d;
`ifdef CP0_EPC_STACK_EN
            stk_q    <= stk_d;
            depth_q  <= depth_d;
`else
            epc_q    <= epc_d;
`endif
        end
    end

    always_comb begin
        case (bus.cp0_addr)
            5'd12:   bus.cp0_rdata = status_q;
            5'd13:   bus.cp0_rdata = cause_q;
            5'd14:   bus.cp0_rdata = epc_top;
            5'd15:   bus.cp0_rdata = isr_q;
            default: bus.cp0_rdata = 32'd0;
        endcase
    end

    assign bus.take       = take;
    assign bus.vector     = VECTOR;
    assign bus.epc_out    = epc_top;
    assign bus.status_out = status_q;
    assign bus.isr_out    = isr_q;
endmodule

// File: doc/cp0_int_regs.md
# cp0_int_regs

Coprocessor-0 interrupt register block, directly downstream of the interrupt priority encoder. It takes that encoder's combinational request and its proposed EPC/Cause/Status values, and commits them at an instruction boundary. It feeds Status back to the encoder and sequences interrupt entry, pipeline flush and `eret` return. It also provides the `mtc0`/`mfc0` register port.

## Interface
Parameters:
- `VECTOR`, default 32'h0000_0008: handler address driven on `vector`.
- `FLUSH_CYCLES`, default 2: blanking cycles after entry (legal range 1–15).

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `int_req` in 1: encoder INT (any unmasked request).
- `int_epc` in 32: proposed EPC from encoder.
- `int_cause` in 32: proposed Cause from encoder (code<<2).
- `int_status` in 32: proposed Status from encoder (old Status | granted bit).
- `boundary` in 1: CPU is at an instruction boundary and may be interrupted.
- `take` out 1: interrupt accepted this cycle; CPU redirects PC.
- `vector` out 32: constant `VECTOR`.
- `eret` in 1: return-from-interrupt strobe.
- `epc_out` out 32: return address for `eret`.
- `cp0_we` in 1: `mtc0` write strobe.
- `cp0_addr` in 5: register number; 12=Status, 13=Cause, 14=EPC, 15=ISR (read-only).
- `cp0_wdata` in 32: `mtc0` data.
- `cp0_rdata` out 32: `mfc0` data; combinational from current registers; 0 for unmapped addresses.
- `status_out` out 32: Status register; feeds the encoder.
- `isr_out` out 32: in-service bits.

## Operation
- Registers: Status, Cause, EPC and ISR (in-service). A Status bit of 1 masks that line.
- FSM states are IDLE and FLUSH, with a 4-bit flush counter.
- `take` = (state==IDLE) & `int_req` & `boundary` & ~`full`. It is combinational. Without the macro, `full` is constant 0.
- On a `take` edge:
  - Status←`int_status`, Cause←`int_cause`, EPC←`int_epc`.
  - ISR←ISR | (`int_status` & ~Status), which adds the granted bit.
  - Counter←`FLUSH_CYCLES`-1; state→FLUSH.
- FLUSH:
  - `take` is held 0.
  - `eret` and `cp0_we` are ignored, because they belong to flushed instructions.
  - The counter decrements each cycle; state→IDLE after the cycle in which the counter is 0.
- `eret` in IDLE without a take:
  - Let L = lowest set bit of ISR.
  - ISR←ISR & ~L; Status←Status & ~L.
  - If ISR==0, ISR and Status are unchanged.
  - `epc_out` = EPC, combinational, valid during the `eret` cycle.
- `cp0_we` in IDLE without a take: writes Status/Cause/EPC per `cp0_addr`. Writes to ISR or unmapped addresses are dropped.
- Priority in IDLE: take > eret > cp0_we. A losing `eret`/`cp0_we` is dropped and the CPU reissues it after the flush.
- `eret` together with `cp0_we` in the same cycle: `eret` is applied and the write is dropped.

## Timing
- Reset values: Status=32'hFFFF_FFFF (all masked), Cause=0, EPC=0, ISR=0, state=IDLE, counter=0, `take`=0.
- `take` has zero latency from inputs. Register updates are visible the next cycle.
- The encoder sees the new Status one cycle after `take`, which is inside FLUSH, so no double entry occurs.
- `FLUSH_CYCLES`=N gives N cycles with `take`=0 after the take cycle. The earliest next take is at cycle N+1.
- Reset asserted in FLUSH returns to IDLE with reset values; the flush is abandoned.
- `int_req` held while `boundary`=0 stays pending with no state change.

## Configuration
- `CP0_EPC_STACK_EN` defined:
  - EPC becomes a 4-deep stack. A take pushes `int_epc`; `eret` pops.
  - `epc_out`, and `cp0_rdata` at 14, show the top of stack. `mtc0` 14 overwrites the top.
  - `full` = depth==4, which blocks `take`.
  - `eret` on an empty stack outputs 0 and the pop is a no-op.
- Undefined: single EPC register; a nested take overwrites it. `full`=0.

## Test plan
- Reset then `mfc0` 12/13/14/15 -> FFFF_FFFF, 0, 0, 0; `take`=0.
- `mtc0` Status=FFFF_FFFB; `int_req`=1, `int_cause`=8, `int_epc`=0x40, `int_status`=FFFF_FFFF, `boundary`=1 -> `take` for 1 cycle; Cause=8, EPC=0x40, ISR=4; then 2 cycles with `take`=0.
- `eret` issued during FLUSH, then in IDLE -> first is ignored; second gives ISR=0, Status=FFFF_FFFB, `epc_out`=0x40.
- `take` and `eret` in the same cycle -> entry is performed; ISR is not cleared.
- `int_req` high with `boundary` low for 5 cycles, then high -> `take` exactly in the first `boundary` cycle.
- With `CP0_EPC_STACK_EN`: 4 nested takes with EPCs 0x10/0x20/0x30/0x40 -> 5th is blocked. Then `eret`×4 -> `epc_out` 0x40, 0x30, 0x20, 0x10.
